imem_fetch_ctrl: RTL



---
 rtl/imem_fetch_ctrl_if.sv | 37 +++
 rtl/imem_fetch_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer (master) and ROM/decode/branch logic (slave).
// FETCH_PERF_EN adds the two performance counter outputs.
interface imem_fetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        fault;
    logic [63:0] fault_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, perf_fetched, perf_stall,
        input  imem_instr, out_ready, redirect_valid, redirect_pc, halt
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, perf_fetched, perf_stall,
        output imem_instr, out_ready, redirect_valid, redirect_pc, halt
    );
`else
    modport master (
        output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
        input  imem_instr, out_ready, redirect_valid, redirect_pc, halt
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
        output imem_instr, out_ready, redirect_valid, redirect_pc, halt
    );
`endif
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches from a combinational ROM into an in-order buffer
// and faults on illegal PCs. FETCH_PERF_EN adds fetched/stall counters.
module imem_fetch_ctrl #(
    parameter int unsigned MEM_SIZE  = 1024,
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    imem_fetch_ctrl_if.master fetch_bus
);
    localparam int unsigned      PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam logic [63:0]      MEM_LIMIT = 64'(MEM_SIZE);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [63:0]      r_pc;
    logic [63:0]      r_fault_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_buf_instr [BUF_DEPTH];
    logic [63:0]      r_buf_pc    [BUF_DEPTH];

    logic w_pc_legal;
    logic w_out_valid;
    logic w_pop;
    logic w_fetch_ok;
    logic w_full;
    logic w_push;
    logic w_fault_det;

    // pc+3 is a full 64-bit sum so addresses near the top of the space stay illegal
    assign w_pc_legal  = (r_pc[1:0] == 2'b00) && ((r_pc + 64'd3) < MEM_LIMIT);
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && fetch_bus.out_ready && !fetch_bus.redirect_valid;
    assign w_fetch_ok  = (r_state == ST_RUN) && !fetch_bus.halt && !fetch_bus.redirect_valid;
    assign w_full      = (r_count == DEPTH_C);
    assign w_push      = w_fetch_ok && w_pc_legal && (!w_full || w_pop);
    assign w_fault_det = w_fetch_ok && !w_pc_legal;

    always_comb begin
        w_state_next = r_state;
        if (fetch_bus.redirect_valid) begin
            w_state_next = ST_RUN;
        end else if (w_fault_det) begin
            w_state_next = ST_FAULT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_fault_pc <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (fetch_bus.redirect_valid) begin
            r_pc       <= fetch_bus.redirect_pc;
            r_fault_pc <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 64'd4;
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_fault_det) begin
                r_fault_pc <= r_pc;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible once count covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_tail] <= fetch_bus.imem_instr;
            r_buf_pc[r_tail]    <= r_pc;
        end
    end

    assign fetch_bus.imem_addr = r_pc;
    assign fetch_bus.out_valid = w_out_valid;
    assign fetch_bus.out_instr = w_out_valid ? r_buf_instr[r_head] : 32'd0;
    assign fetch_bus.out_pc    = w_out_valid ? r_buf_pc[r_head] : 64'd0;
    assign fetch_bus.fault     = (r_state == ST_FAULT);
    assign fetch_bus.fault_pc  = r_fault_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = w_fetch_ok && w_pc_legal && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign fetch_bus.perf_fetched = r_perf_fetched;
    assign fetch_bus.perf_stall   = r_perf_stall;
`endif

`ifndef SYNTHESIS
    a_instr_known: assert property (@(posedge clk) disable iff (reset)
        w_push |-> !$isunknown(fetch_bus.imem_instr));
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        r_count <= DEPTH_C);
`endif
endmodule
